// File: rtl/if_stage_ctrl.sv
// Instruction-fetch front end: PC register, IF/ID pipeline register, imem fetch
// handshake with a one-entry hold buffer, and stall/flush performance counters.
module if_stage_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
  parameter int unsigned CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             PcWrite,
  input  logic             IFID_Write,
  input  logic             Bubble,
  input  logic [1:0]       ID_pcSel,
  input  logic [31:0]      br_target,
  input  logic [31:0]      j_target,
  input  logic [31:0]      jr_target,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_rdata,
  input  logic             imem_ready,
  output logic [31:0]      if_pc,
  output logic [31:0]      IFID_instr,
  output logic [31:0]      IFID_pc4,
  output logic             IFID_valid,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic {FETCH, HOLD} state_e;

  state_e           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      hold_q, hold_d;
  logic [31:0]      instr_q, instr_d;
  logic [31:0]      pc4_q, pc4_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;

  logic        accept;
  logic [31:0] pc_plus4;
  logic [31:0] next_pc;

  assign accept   = PcWrite & IFID_Write & ~Bubble;
  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    unique case (ID_pcSel)
      2'b00:   next_pc = pc_plus4;
      2'b01:   next_pc = br_target;
      2'b10:   next_pc = j_target;
      default: next_pc = jr_target;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    hold_d  = hold_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    stall_d = stall_q;
    flush_d = flush_q;

    if (Bubble) begin
      // Redirect wins over everything; a fetch completing this cycle is dropped.
      instr_d = NOP_INSTR;
      pc4_d   = '0;
      valid_d = 1'b0;
      pc_d    = next_pc;
      state_d = FETCH;
      flush_d = flush_q + CNT_W'(1);
    end else begin
      if (!(accept && (state_q == HOLD || imem_ready)))
        stall_d = stall_q + CNT_W'(1);

      unique case (state_q)
        FETCH: begin
          if (imem_ready) begin
            if (accept) begin
              instr_d = imem_rdata;
              pc4_d   = pc_plus4;
              valid_d = 1'b1;
              pc_d    = next_pc;
            end else begin
              hold_d  = imem_rdata;
              state_d = HOLD;
              if (IFID_Write) begin
                instr_d = NOP_INSTR;
                pc4_d   = '0;
                valid_d = 1'b0;
              end
            end
          end else if (IFID_Write) begin
            instr_d = NOP_INSTR;
            pc4_d   = '0;
            valid_d = 1'b0;
          end
        end
        HOLD: begin
          if (accept) begin
            instr_d = hold_q;
            pc4_d   = pc_plus4;
            valid_d = 1'b1;
            pc_d    = next_pc;
            state_d = FETCH;
          end
        end
        default: state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      hold_q  <= '0;
      instr_q <= NOP_INSTR;
      pc4_q   <= '0;
      valid_q <= 1'b0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      hold_q  <= hold_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign imem_req   = (state_q == FETCH);
  assign imem_addr  = pc_q;
  assign if_pc      = pc_q;
  assign IFID_instr = instr_q;
  assign IFID_pc4   = pc4_q;
  assign IFID_valid = valid_q;
  assign stall_cnt  = stall_q;
  assign flush_cnt  = flush_q;

endmodule
